// File: rtl/ngp_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions and
// instruction field positions.
package ngp_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOTX = 3'b011,
    OP_ADD  = 3'b100,
    OP_INCX = 3'b101,
    OP_SUB  = 3'b110,
    OP_DECX = 3'b111
  } opcode_e;

  // Flag vector is {lt, eq, gt}; the jump mask uses the same bit order.
  localparam int FLAG_LT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_GT = 0;

  localparam logic [2:0] FLAGS_RESET = 3'b010;

  localparam int INSTR_MEMSEL   = 14;
  localparam int INSTR_DST_LSB  = 7;
  localparam int INSTR_OP_LSB   = 4;
  localparam int INSTR_ZY       = 3;
  localparam int INSTR_MASK_LSB = 0;

endpackage

// File: rtl/ngpalu_w.sv
// Combinational execute datapath: operand select, ALU, flags and jump
// decision for one instruction.
module ngpalu_w
  import ngp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              memsel_i,
  input  logic              zy_i,
  input  opcode_e           opcode_i,
  input  logic [2:0]        mask_i,
  input  logic [DATA_W-1:0] rx_i,
  input  logic [DATA_W-1:0] ry_i,
  input  logic [DATA_W-1:0] rx_mem_i,
  output logic [DATA_W-1:0] result_o,
  output logic [2:0]        flags_o,
  output logic              jmp_o
);

  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;

  always_comb begin
    x = memsel_i ? rx_mem_i : rx_i;
    y = zy_i ? '0 : ry_i;

    result_o = '0;
    case (opcode_i)
      OP_AND:  result_o = x & y;
      OP_OR:   result_o = x | y;
      OP_XOR:  result_o = x ^ y;
      OP_NOTX: result_o = ~x;
      OP_ADD:  result_o = x + y;
      OP_INCX: result_o = x + DATA_W'(1);
      OP_SUB:  result_o = x - y;
      OP_DECX: result_o = x - DATA_W'(1);
      default: result_o = '0;
    endcase

    flags_o          = '0;
    flags_o[FLAG_LT] = result_o[DATA_W-1];
    flags_o[FLAG_EQ] = (result_o == '0);
    flags_o[FLAG_GT] = ~flags_o[FLAG_LT] & ~flags_o[FLAG_EQ];

    // Mask and flags share bit order, so the jump is a masked OR.
    jmp_o = |(mask_i & flags_o);
  end

endmodule

// File: rtl/exec_stage.sv
// Single-entry execute pipeline stage: valid/ready handshake around the ALU,
// result register with flush, and saturating op/jump statistics.
module exec_stage
  import ngp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] rx_reg,
  input  logic [DATA_W-1:0] ry_reg,
  input  logic [DATA_W-1:0] rx_mem_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [2:0]        dst,
  output logic              jmp,
  output logic [2:0]        flags,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  jmp_count
);

  logic [DATA_W-1:0] alu_result;
  logic [2:0]        alu_flags;
  logic              alu_jmp;
  logic              accept;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [2:0]        dst_q, dst_d;
  logic              jmp_q, jmp_d;
  logic [2:0]        flags_q, flags_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]  jmp_cnt_q, jmp_cnt_d;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[15], instruction[13:10]};

  ngpalu_w #(.DATA_W(DATA_W)) u_alu (
    .memsel_i (instruction[INSTR_MEMSEL]),
    .zy_i     (instruction[INSTR_ZY]),
    .opcode_i (opcode_e'(instruction[INSTR_OP_LSB +: 3])),
    .mask_i   (instruction[INSTR_MASK_LSB +: 3]),
    .rx_i     (rx_reg),
    .ry_i     (ry_reg),
    .rx_mem_i (rx_mem_reg),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .jmp_o    (alu_jmp)
  );

  // Reset gates readiness so nothing presented during reset is taken.
  assign in_ready = (~valid_q | out_ready) & ~flush & ~rst;

  always_comb begin
    accept    = in_valid & in_ready;
    valid_d   = valid_q;
    out_d     = out_q;
    dst_d     = dst_q;
    jmp_d     = jmp_q;
    flags_d   = flags_q;
    op_cnt_d  = op_cnt_q;
    jmp_cnt_d = jmp_cnt_q;

    if (accept) begin
      valid_d = 1'b1;
      out_d   = alu_result;
      dst_d   = instruction[INSTR_DST_LSB +: 3];
      jmp_d   = alu_jmp;
      flags_d = alu_flags;
      if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
      if (alu_jmp && (jmp_cnt_q != '1)) jmp_cnt_d = jmp_cnt_q + CNT_W'(1);
    end else if (flush || out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      out_q     <= '0;
      dst_q     <= '0;
      jmp_q     <= 1'b0;
      flags_q   <= FLAGS_RESET;
      op_cnt_q  <= '0;
      jmp_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      out_q     <= out_d;
      dst_q     <= dst_d;
      jmp_q     <= jmp_d;
      flags_q   <= flags_d;
      op_cnt_q  <= op_cnt_d;
      jmp_cnt_q <= jmp_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign dst       = dst_q;
  assign jmp       = jmp_q;
  assign flags     = flags_q;
  assign op_count  = op_cnt_q;
  assign jmp_count = jmp_cnt_q;

endmodule
